// File: rtl/core_pkg.sv
// core_pkg: types and defaults shared by the fetch stage.
//   fetch_entry_t       : one fetched instruction together with its PC
//   RESET_PC_DEFAULT    : default fetch address after reset
//   QUEUE_DEPTH_DEFAULT : default instruction-queue depth (also request credit)
//   word_align()        : clears the byte-offset bits of an address
package core_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          QUEUE_DEPTH_DEFAULT = 2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t between the memory response
// path and decode. Head entry is read directly from the storage registers so
// it is visible in the cycle after the push.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : empties the queue (wins over push)
//   push        : write push_entry at the tail (ignored when full without pop)
//   pop         : drop the head entry (ignored when empty)
//   head_entry  : current head entry (valid when !empty)
//   count       : number of stored entries
//   empty, full : occupancy flags
module fetch_queue
  import core_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic do_pop;
  logic do_push;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;

  // A push into a full queue is allowed only if the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: the count decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= push_entry;
  end

  assign head_entry = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Issues in-order word requests from the
// fetch PC, buffers returned instructions with their PCs and presents them to
// decode. A redirect flushes the queue and turns every request still in flight
// into a response that is silently dropped.
//   clk, rst_n          : clock, synchronous active-low reset
//   imem_req_*          : request channel (valid/ready, word address)
//   imem_resp_*         : in-order response channel, never back-pressured
//   redirect_valid/target : new PC from execute (target[1:0] ignored)
//   dec_valid/ready, dec_pc, dec_instr : instruction handed to decode
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr
);

  localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
  // Stale responses can pile up across closely spaced redirects (new requests
  // are issued while older stale ones are still draining), so the discard
  // counter gets headroom beyond a single queue's worth.
  localparam int DISC_W = CNT_W + 3;

  logic [31:0]       pc_reg, pc_next;
  logic [31:0]       resp_pc_reg, resp_pc_next;   // PC of the next kept response
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [DISC_W-1:0] discard_reg, discard_next;

  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [CNT_W-1:0] q_count;
  logic             q_empty;
  logic             q_full;

  logic [CNT_W:0]   in_use;
  logic             has_credit;
  logic             req_fire;
  logic             resp_keep;
  logic             resp_drop;
  logic             q_pop;
  logic [DISC_W:0]  discard_sum;

  // Every outstanding request owns a queue slot, so the queue can never
  // overflow and responses never need to be stalled.
  assign in_use     = {1'b0, q_count} + {1'b0, outstanding_reg};
  assign has_credit = !q_full && (in_use < (CNT_W + 1)'(QUEUE_DEPTH));

  assign imem_req_valid = rst_n && !redirect_valid && has_credit;
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (discard_reg != '0);
  assign resp_keep = imem_resp_valid && (discard_reg == '0) && !redirect_valid;

  assign push_entry.pc    = resp_pc_reg;
  assign push_entry.instr = imem_resp_data;

  assign q_pop = !q_empty && dec_ready;

  // On redirect, everything outstanding becomes stale; a response arriving in
  // the redirect cycle itself is dropped and so leaves the stale total.
  assign discard_sum = {1'b0, discard_reg} + (DISC_W + 1)'(outstanding_reg);

  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (redirect_valid) begin
      pc_next          = word_align(redirect_target);
      resp_pc_next     = word_align(redirect_target);
      outstanding_next = '0;
      if (imem_resp_valid && (discard_sum != '0))
        discard_next = DISC_W'(discard_sum - (DISC_W + 1)'(1));
      else
        discard_next = DISC_W'(discard_sum);
    end else begin
      if (req_fire)  pc_next      = pc_reg + 32'd4;
      if (resp_keep) resp_pc_next = resp_pc_reg + 32'd4;
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(resp_keep);
      if (resp_drop) discard_next = discard_reg - DISC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else begin
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (resp_keep),
    .push_entry (push_entry),
    .pop        (q_pop),
    .head_entry (head_entry),
    .count      (q_count),
    .empty      (q_empty),
    .full       (q_full)
  );

  assign dec_valid = !q_empty;
  assign dec_pc    = head_entry.pc;
  assign dec_instr = head_entry.instr;

endmodule
